// File: rtl/bp_cache_req_arbiter.sv
// rtl/bp_cache_req_arbiter.sv - shares one LCE request channel between I$ and D$ miss slots
// Define BP_CACHE_REQ_ARB_FIXED_PRIO_EN for fixed D$-first priority instead of round-robin.
module bp_cache_req_arbiter #(
    parameter int req_width_p      = 128,
    parameter int metadata_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [req_width_p-1:0]      icache_req_i,
    input  logic                        icache_req_v_i,
    output logic                        icache_req_ready_o,
    input  logic [metadata_width_p-1:0] icache_req_metadata_i,
    input  logic                        icache_req_metadata_v_i,
    output logic                        icache_req_complete_o,
    input  logic [req_width_p-1:0]      dcache_req_i,
    input  logic                        dcache_req_v_i,
    output logic                        dcache_req_ready_o,
    input  logic [metadata_width_p-1:0] dcache_req_metadata_i,
    input  logic                        dcache_req_metadata_v_i,
    output logic                        dcache_req_complete_o,
    output logic [req_width_p-1:0]      lce_req_o,
    output logic                        lce_req_v_o,
    input  logic                        lce_req_ready_i,
    output logic [metadata_width_p-1:0] lce_req_metadata_o,
    output logic                        lce_req_metadata_v_o,
    input  logic                        lce_req_complete_i,
    output logic [1:0]                  grant_o
);

    typedef enum logic [1:0] {IDLE, META, BUSY} state_e;

    state_e                             state_q, state_d;
    logic [1:0]                         grant_q, grant_d;
    logic [1:0][req_width_p-1:0]        req_q;
    logic [1:0][metadata_width_p-1:0]   meta_q;
    logic [1:0]                         req_full_q, meta_full_q;

    logic [1:0][req_width_p-1:0]        req_in;
    logic [1:0][metadata_width_p-1:0]   meta_in;
    logic [1:0]                         req_v, meta_v;
    logic [1:0]                         eligible, clear, complete;
    logic                               winner;
    logic                               meta_out_v;

    assign req_in  = {dcache_req_i, icache_req_i};
    assign meta_in = {dcache_req_metadata_i, icache_req_metadata_i};
    assign req_v   = {dcache_req_v_i, icache_req_v_i};
    assign meta_v  = {dcache_req_metadata_v_i, icache_req_metadata_v_i};

    // Index 0 is the I$, index 1 the D$; grant_q is one-hot and nonzero only while in flight.
    assign eligible = req_full_q & meta_full_q & ~grant_q;

`ifdef BP_CACHE_REQ_ARB_FIXED_PRIO_EN
    assign winner = eligible[1];
`else
    logic last_grant_q;

    assign winner = (&eligible) ? ~last_grant_q : eligible[1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= 1'b0;
        end else if (lce_req_v_o) begin
            last_grant_q <= winner;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lce_req_v_o = 1'b0;
        meta_out_v  = 1'b0;
        complete    = 2'b00;
        clear       = 2'b00;
        case (state_q)
            IDLE: begin
                lce_req_v_o = lce_req_ready_i & (|eligible);
                if (lce_req_v_o) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    state_d = META;
                end
            end
            META, BUSY: begin
                meta_out_v = (state_q == META);
                if (lce_req_complete_i) begin
                    complete = grant_q;
                    clear    = grant_q;
                    grant_d  = 2'b00;
                    state_d  = IDLE;
                end else begin
                    state_d  = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_q       <= '0;
            meta_q      <= '0;
            req_full_q  <= 2'b00;
            meta_full_q <= 2'b00;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (clear[s]) begin
                    req_full_q[s]  <= 1'b0;
                    meta_full_q[s] <= 1'b0;
                end else begin
                    if (req_v[s] && !req_full_q[s]) begin
                        req_q[s]      <= req_in[s];
                        req_full_q[s] <= 1'b1;
                    end
                    // Metadata only lands once its request is held, and only the first beat counts.
                    if (meta_v[s] && req_full_q[s] && !meta_full_q[s]) begin
                        meta_q[s]      <= meta_in[s];
                        meta_full_q[s] <= 1'b1;
                    end
                end
            end
        end
    end

    assign lce_req_o             = lce_req_v_o ? req_q[winner] : '0;
    assign lce_req_metadata_v_o  = meta_out_v;
    assign lce_req_metadata_o    = meta_out_v ? meta_q[grant_q[1]] : '0;
    assign icache_req_ready_o    = ~req_full_q[0];
    assign dcache_req_ready_o    = ~req_full_q[1];
    assign icache_req_complete_o = complete[0];
    assign dcache_req_complete_o = complete[1];
    assign grant_o               = grant_q;

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// tb/tb_bp_cache_req_arbiter.sv - self-checking bench for bp_cache_req_arbiter
module tb_bp_cache_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] ireq = '0, dreq = '0;
    logic         iv = 1'b0, dv = 1'b0, imv = 1'b0, dmv = 1'b0;
    logic [7:0]   imeta = '0, dmeta = '0;
    logic         lce_rdy = 1'b1, cpl = 1'b0;

    logic         iready, dready, icpl, dcpl, lce_v, lce_mv;
    logic [127:0] lce_req;
    logic [7:0]   lce_meta;
    logic [1:0]   grant;

    int n_checks = 0;
    int n_fail = 0;

    bp_cache_req_arbiter dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .icache_req_i(ireq), .icache_req_v_i(iv), .icache_req_ready_o(iready),
        .icache_req_metadata_i(imeta), .icache_req_metadata_v_i(imv), .icache_req_complete_o(icpl),
        .dcache_req_i(dreq), .dcache_req_v_i(dv), .dcache_req_ready_o(dready),
        .dcache_req_metadata_i(dmeta), .dcache_req_metadata_v_i(dmv), .dcache_req_complete_o(dcpl),
        .lce_req_o(lce_req), .lce_req_v_o(lce_v), .lce_req_ready_i(lce_rdy),
        .lce_req_metadata_o(lce_meta), .lce_req_metadata_v_o(lce_mv),
        .lce_req_complete_i(cpl), .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each source holds at most one request; the LCE serves one at a time,
    // metadata follows one cycle after issue, completion frees the source.
    logic [127:0] m_req [2];
    logic [7:0]   m_meta [2];
    bit           m_full [2];
    bit           m_mfull [2];
    int           m_phase;
    int           m_gnt;
    int           m_last;

    always @(negedge clk) begin : model_cmp
        bit           el0, el1, e_v, e_mv;
        int           w;
        logic [127:0] e_req;
        logic [7:0]   e_meta;
        logic [1:0]   e_cpl, e_grant;
        bit           vv [2];
        bit           mv [2];
        logic [127:0] din [2];
        logic [7:0]   mdin [2];
        if (!rst_n) begin
            chk("rst_iready", iready, 1); chk("rst_dready", dready, 1);
            chk("rst_lce_v", lce_v, 0);   chk("rst_lce_mv", lce_mv, 0);
            chk("rst_icpl", icpl, 0);     chk("rst_dcpl", dcpl, 0);
            chk("rst_grant", grant, 0);   chk("rst_lce_req", lce_req, 0);
            chk("rst_lce_meta", lce_meta, 0);
            for (int s = 0; s < 2; s++) begin
                m_full[s] = 0; m_mfull[s] = 0; m_req[s] = '0; m_meta[s] = '0;
            end
            m_phase = 0; m_gnt = 0; m_last = 0;
        end else begin
            e_v = 0; e_mv = 0; e_req = '0; e_meta = '0; e_cpl = '0; e_grant = '0; w = 0;
            if (m_phase == 0) begin
                el0 = m_full[0] && m_mfull[0];
                el1 = m_full[1] && m_mfull[1];
`ifdef BP_CACHE_REQ_ARB_FIXED_PRIO_EN
                w = el1 ? 1 : 0;
`else
                if (el0 && el1) w = (m_last == 0) ? 1 : 0;
                else            w = el1 ? 1 : 0;
`endif
                e_v = lce_rdy && (el0 || el1);
                if (e_v) e_req = m_req[w];
            end else begin
                e_grant = 2'(1 << m_gnt);
                if (cpl) e_cpl = 2'(1 << m_gnt);
                if (m_phase == 1) begin
                    e_mv = 1;
                    e_meta = m_meta[m_gnt];
                end
            end
            chk("iready", iready, !m_full[0]); chk("dready", dready, !m_full[1]);
            chk("lce_v", lce_v, e_v);         chk("lce_mv", lce_mv, e_mv);
            chk("icpl", icpl, e_cpl[0]);      chk("dcpl", dcpl, e_cpl[1]);
            chk("grant", grant, e_grant);
            if (e_v)  chk("lce_req", lce_req, e_req);
            if (e_mv) chk("lce_meta", lce_meta, e_meta);

            vv[0] = iv; vv[1] = dv; mv[0] = imv; mv[1] = dmv;
            din[0] = ireq; din[1] = dreq; mdin[0] = imeta; mdin[1] = dmeta;
            for (int s = 0; s < 2; s++) begin
                if (!m_full[s] && vv[s]) begin
                    m_full[s] = 1; m_req[s] = din[s];
                end else if (m_full[s] && !m_mfull[s] && mv[s]) begin
                    m_mfull[s] = 1; m_meta[s] = mdin[s];
                end
            end
            if (m_phase == 0) begin
                if (e_v) begin
                    m_phase = 1; m_gnt = w; m_last = w;
                end
            end else if (cpl) begin
                m_full[m_gnt] = 0; m_mfull[m_gnt] = 0; m_phase = 0;
            end else begin
                m_phase = 2;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
        iv = 0; dv = 0; imv = 0; dmv = 0; cpl = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc; cyc; rst_n = 1'b1;

        // single I$ miss, cycles 0..7
        cyc; ireq = 128'hA5; iv = 1;
        cyc; imv = 1; imeta = 8'h3;
        cyc; #2 chk("t1_issue_v", lce_v, 1); chk("t1_issue_req", lce_req, 128'hA5);
        cyc; #2 chk("t1_meta", lce_meta, 8'h3); chk("t1_grant", grant, 2'b01);
        cyc; cyc;
        cyc; cpl = 1; #2 chk("t1_icpl", icpl, 1); chk("t1_iready_busy", iready, 0);
        cyc; #2 chk("t1_iready", iready, 1);

        // simultaneous pair: D$ first, I$ the cycle after D$ completes
        cyc; ireq = 128'h11; dreq = 128'h22; iv = 1; dv = 1;
        cyc; imv = 1; dmv = 1; imeta = 8'h1; dmeta = 8'h2;
        cyc; #2 chk("p1_first", lce_req, 128'h22);
        cyc;
        cyc; cpl = 1; #2 chk("p1_dcpl", dcpl, 1);
        cyc; #2 chk("p1_second_v", lce_v, 1); chk("p1_second", lce_req, 128'h11);
        cyc;
        cyc; cpl = 1;
        // lone D$ miss leaves last_grant on the D$
        cyc; dreq = 128'h33; dv = 1;
        cyc; dmv = 1; dmeta = 8'h4;
        cyc; cyc;
        cyc; cpl = 1;
        // second pair: round-robin now favours the I$
        cyc; ireq = 128'h44; dreq = 128'h55; iv = 1; dv = 1;
        cyc; imv = 1; dmv = 1; imeta = 8'h5; dmeta = 8'h6;
`ifdef BP_CACHE_REQ_ARB_FIXED_PRIO_EN
        cyc; #2 chk("p2_first", lce_req, 128'h55);
`else
        cyc; #2 chk("p2_first", lce_req, 128'h44);
`endif
        cyc;
        cyc; cpl = 1;
`ifdef BP_CACHE_REQ_ARB_FIXED_PRIO_EN
        cyc; #2 chk("p2_second", lce_req, 128'h44);
`else
        cyc; #2 chk("p2_second", lce_req, 128'h55);
`endif
        cyc;
        cyc; cpl = 1;

        // LCE back-pressure
        lce_rdy = 0;
        cyc; ireq = 128'h66; iv = 1;
        cyc; imv = 1; imeta = 8'h8;
        for (int k = 0; k < 10; k++) begin
            cyc; #2 chk("bp_hold", lce_v, 0);
        end
        cyc; lce_rdy = 1; #2 chk("bp_release_v", lce_v, 1); chk("bp_release_req", lce_req, 128'h66);
        cyc;
        cyc; cpl = 1;

        // completion during META
        cyc; dreq = 128'h77; dv = 1;
        cyc; dmv = 1; dmeta = 8'h7;
        cyc; #2 chk("cm_issue", lce_v, 1);
        cyc; cpl = 1; #2 chk("cm_mv", lce_mv, 1); chk("cm_meta", lce_meta, 8'h7); chk("cm_dcpl", dcpl, 1);
        cyc; #2 chk("cm_idle_grant", grant, 0); chk("cm_dready", dready, 1);

        // stray metadata and completion
        cyc; imv = 1; imeta = 8'h9;
        cyc; cpl = 1; #2 chk("stray_icpl", icpl, 0); chk("stray_dcpl", dcpl, 0);
        cyc; #2 chk("stray_iready", iready, 1); chk("stray_grant", grant, 0);
        cyc; ireq = 128'h88; iv = 1;
        cyc; imv = 1; imeta = 8'h0A;
        cyc;
        cyc; #2 chk("stray_meta_new", lce_meta, 8'h0A);
        cyc; cpl = 1;

        // reset during BUSY
        cyc; ireq = 128'h99; iv = 1;
        cyc; imv = 1; imeta = 8'h5;
        cyc; cyc;
        cyc; #1 rst_n = 0;
        #1 chk("mr_iready", iready, 1); chk("mr_grant", grant, 0);
        chk("mr_lce_v", lce_v, 0); chk("mr_lce_mv", lce_mv, 0);
        cyc; cpl = 1; #2 chk("mr_icpl", icpl, 0);
        cyc; rst_n = 1;
        cyc; ireq = 128'hAB; iv = 1;
        cyc; imv = 1; imeta = 8'hC;
        cyc; #2 chk("post_rst_req", lce_req, 128'hAB);
        cyc; #2 chk("post_rst_meta", lce_meta, 8'hC);
        cyc; cpl = 1; #2 chk("post_rst_icpl", icpl, 1);
        cyc; cyc;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
